avr_io_irqctl: RTL and testbench

//  Registered interrupt controller sitting between the I/O peripherals' irq lines and the avr_core

---
 rtl/avr_io_irqctl.sv | 125 ++++++++++++
 tb/tb_avr_io_irqctl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_io_irqctl.sv
// rtl/avr_io_irqctl.sv - registered interrupt controller for the avr_core I/O window
//
// Purpose: latches edge events from peripheral irq lines, applies a software
// mask, selects the lowest active source and presents it to the core as a
// registered iflag/ivect pair. A taken edge source is cleared on ack.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_io_re, i_io_we      window-qualified I/O read/write strobes
//   i_io_a                register index: 0 PEND, 1 MASK, 2 EDGE, 3 STAT
//   i_io_din, o_io_dout   write data in, read data out (8'h00 when not read)
//   i_irq_in              source request lines, active high, synchronous
//   i_ack, i_ack_vect     one-cycle acknowledge of the vectored index
//   o_iflag, o_ivect      registered interrupt request and vector to the core
module avr_io_irqctl #(
  parameter int          N_IRQ     = 4,
  parameter int          VEC_WIDTH = 2,
  parameter logic [7:0]  EDGE_RST  = 8'hFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_io_re,
  input  logic                 i_io_we,
  input  logic [1:0]           i_io_a,
  input  logic [7:0]           i_io_din,
  output logic [7:0]           o_io_dout,
  input  logic [N_IRQ-1:0]     i_irq_in,
  input  logic                 i_ack,
  input  logic [VEC_WIDTH-1:0] i_ack_vect,
  output logic                 o_iflag,
  output logic [VEC_WIDTH-1:0] o_ivect
);

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_EDGE = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic [N_IRQ-1:0]     r_irq_prev;
  logic [N_IRQ-1:0]     r_pend_lat;
  logic [N_IRQ-1:0]     r_mask;
  logic [N_IRQ-1:0]     r_edge;
  logic                 r_iflag;
  logic [VEC_WIDTH-1:0] r_ivect;

  logic [N_IRQ-1:0]     w_pend;
  logic [N_IRQ-1:0]     w_active;
  logic [N_IRQ-1:0]     w_set;
  logic [N_IRQ-1:0]     w_clr;
  logic [N_IRQ-1:0]     w_edge_next;
  logic [N_IRQ-1:0]     w_pend_lat_next;
  logic                 w_iflag_next;
  logic [VEC_WIDTH-1:0] w_ivect_next;

  // Edge sources show the latch, level sources show the raw line.
  assign w_pend   = (r_pend_lat & r_edge) | (i_irq_in & ~r_edge);
  assign w_active = w_pend & r_mask;

  assign w_edge_next = (i_io_we && i_io_a == A_EDGE) ? i_io_din[N_IRQ-1:0] : r_edge;

  always_comb begin
    w_set = i_irq_in & ~r_irq_prev & r_edge;
    w_clr = '0;
    if (i_io_we && i_io_a == A_PEND) begin
      w_clr = i_io_din[N_IRQ-1:0];
    end
    // An ack_vect outside 0..N_IRQ-1 matches no bit and is ignored.
    for (int i = 0; i < N_IRQ; i++) begin
      if (i_ack && (int'(i_ack_vect) == i)) begin
        w_clr[i] = 1'b1;
      end
    end
    // Set wins over clear; masking with the next EDGE value drops the latch
    // of any source switched to level mode.
    w_pend_lat_next = (w_set | (r_pend_lat & ~w_clr)) & w_edge_next;
  end

  always_comb begin
    w_iflag_next = |w_active;
    w_ivect_next = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_ivect_next = VEC_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_irq_prev <= '0;
      r_pend_lat <= '0;
      r_mask     <= '0;
      r_edge     <= EDGE_RST[N_IRQ-1:0];
      r_iflag    <= 1'b0;
      r_ivect    <= '0;
    end else begin
      r_irq_prev <= i_irq_in;
      r_pend_lat <= w_pend_lat_next;
      r_edge     <= w_edge_next;
      if (i_io_we && i_io_a == A_MASK) begin
        r_mask <= i_io_din[N_IRQ-1:0];
      end
      r_iflag <= w_iflag_next;
      r_ivect <= w_ivect_next;
    end
  end

  // Read mux reflects current state, so a same-cycle write reads the old value.
  always_comb begin
    o_io_dout = 8'h00;
    if (i_io_re) begin
      case (i_io_a)
        A_PEND:  o_io_dout = 8'(w_pend);
        A_MASK:  o_io_dout = 8'(r_mask);
        A_EDGE:  o_io_dout = 8'(r_edge);
        A_STAT:  o_io_dout = {r_iflag, 7'(r_ivect)};
        default: o_io_dout = 8'h00;
      endcase
    end
  end

  assign o_iflag = r_iflag;
  assign o_ivect = r_ivect;

endmodule

// File: tb/tb_avr_io_irqctl.sv
// tb/tb_avr_io_irqctl.sv - self-checking bench for avr_io_irqctl
module tb_avr_io_irqctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       io_re, io_we;
  logic [1:0] io_a;
  logic [7:0] io_din;
  logic [7:0] io_dout;
  logic [3:0] irq_in;
  logic       ack;
  logic [1:0] ack_vect;
  logic       iflag;
  logic [1:0] ivect;

  typedef struct {
    string      nm;
    logic [7:0] v;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] obs;
  int         n_chk  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  avr_io_irqctl #(.N_IRQ(4), .VEC_WIDTH(2), .EDGE_RST(8'hFF)) dut (
    .i_clk(clk), .i_rst(rst), .i_io_re(io_re), .i_io_we(io_we), .i_io_a(io_a),
    .i_io_din(io_din), .o_io_dout(io_dout), .i_irq_in(irq_in), .i_ack(ack),
    .i_ack_vect(ack_vect), .o_iflag(iflag), .o_ivect(ivect)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    io_re = 1'b1;
    io_a  = a;
    #2;
    d     = io_dout;
    io_re = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_we  = 1'b1;
    io_a   = a;
    io_din = d;
    tick();
    io_we  = 1'b0;
  endtask

  task automatic do_ack(input logic [1:0] v);
    ack      = 1'b1;
    ack_vect = v;
    tick();
    ack      = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    irq_in = m;
    tick();
    irq_in = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.push_back('{"rst_pend", 8'h00});
    exp_q.push_back('{"rst_mask", 8'h00});
    exp_q.push_back('{"rst_edge", 8'h0F});
    exp_q.push_back('{"rst_stat", 8'h00});
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), obs);
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.nm, obs, e.v);
      end
    end
  endtask

  task automatic test_edge_basic();
    wr(2'd1, 8'h0F);
    pulse(4'h4);
    exp_q.push_back('{"t1_pend", 8'h04});
    exp_q.push_back('{"t1_stat_early", 8'h00});
    rd(2'd0, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    rd(2'd3, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    tick();
    exp_q.push_back('{"t1_iflag_ivect", 8'h82});
    obs = {iflag, 5'b0, ivect};
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    do_ack(2'd2);
    tick();
    exp_q.push_back('{"t1_ack_clear", 8'h00});
    rd(2'd3, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_priority_ack();
    pulse(4'hA);
    tick();
    exp_q.push_back('{"t2_first", 8'h81});
    rd(2'd3, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    do_ack(2'd1);
    exp_q.push_back('{"t2_pend_after_ack", 8'h08});
    exp_q.push_back('{"t2_still_1", 8'h81});
    rd(2'd0, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    rd(2'd3, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    tick();
    exp_q.push_back('{"t2_second", 8'h83});
    rd(2'd3, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    do_ack(2'd3);
    tick();
    exp_q.push_back('{"t2_idle", 8'h00});
    rd(2'd3, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_mask();
    // Write and read MASK together: the read must show the old value.
    io_we = 1'b1; io_re = 1'b1; io_a = 2'd1; io_din = 8'h00;
    #2;
    obs = io_dout;
    exp_q.push_back('{"t3_rd_before_wr", 8'h0F});
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    tick();
    io_we = 1'b0; io_re = 1'b0;
    pulse(4'h1);
    tick();
    exp_q.push_back('{"t3_pend_masked", 8'h01});
    exp_q.push_back('{"t3_stat_masked", 8'h00});
    rd(2'd0, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    rd(2'd3, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    wr(2'd1, 8'h01);
    tick();
    exp_q.push_back('{"t3_unmask", 8'h80});
    rd(2'd3, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    do_ack(2'd0);
    wr(2'd1, 8'h0F);
    tick();
  endtask

  task automatic test_level();
    wr(2'd2, 8'h00);
    irq_in = 4'h1;
    exp_q.push_back('{"t4_level_pend", 8'h01});
    rd(2'd0, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    tick();
    do_ack(2'd0);
    tick();
    exp_q.push_back('{"t4_ack_no_effect", 8'h01});
    exp_q.push_back('{"t4_iflag_held", 8'h80});
    rd(2'd0, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    rd(2'd3, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    irq_in = 4'h0;
    tick();
    exp_q.push_back('{"t4_drop", 8'h00});
    obs = {iflag, 5'b0, ivect};
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    wr(2'd2, 8'hFF);
    exp_q.push_back('{"t4_edge_restore", 8'h0F});
    rd(2'd2, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_w1c_vs_edge();
    pulse(4'h4);
    tick();
    // New rising edge on bit 2 together with a W1C of bit 2: set must win.
    irq_in = 4'h4;
    wr(2'd0, 8'h04);
    irq_in = 4'h0;
    exp_q.push_back('{"t5_set_wins", 8'h04});
    rd(2'd0, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    wr(2'd0, 8'h04);
    exp_q.push_back('{"t5_w1c", 8'h00});
    rd(2'd0, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    pulse(4'h3);
    // W1C of bit 0 and ack of bit 1 in the same cycle: both clear.
    ack = 1'b1; ack_vect = 2'd1;
    wr(2'd0, 8'h01);
    ack = 1'b0;
    exp_q.push_back('{"t5_both_clear", 8'h00});
    rd(2'd0, obs);
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    tick();
    tick();
  endtask

  task automatic test_reset_midway();
    wr(2'd2, 8'h05);
    pulse(4'h1);
    tick();
    exp_q.push_back('{"t6_pre_iflag", 8'h80});
    obs = {iflag, 5'b0, ivect};
    e = exp_q.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s got %h want %h", e.nm, obs, e.v); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.push_back('{"t6_pend", 8'h00});
    exp_q.push_back('{"t6_mask", 8'h00});
    exp_q.push_back('{"t6_edge", 8'h0F});
    exp_q.push_back('{"t6_stat", 8'h00});
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), obs);
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e.v) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.nm, obs, e.v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; io_re = 1'b0; io_we = 1'b0; io_a = 2'd0; io_din = 8'h00;
    irq_in = 4'h0; ack = 1'b0; ack_vect = 2'd0;
    test_reset();
    test_edge_basic();
    test_priority_ack();
    test_mask();
    test_level();
    test_w1c_vs_edge();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
